// File: rtl/pulse_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_fifo_if : request/status bundle between pulse sources and FIFO |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface pulse_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              wr_pulse;
   logic              rd_pulse;
   logic [DATA_W-1:0] din;
   logic              clr_err;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_pulse, rd_pulse, din, clr_err,
      input  dout, dout_valid, full, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_pulse, rd_pulse, din, clr_err,
      output dout, dout_valid, full, empty, count, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/pulse_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_fifo : pulse-driven synchronous FIFO with sticky error flags |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module pulse_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  wire logic    clk,
   input  wire logic    rst,
   pulse_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]   rptr_q, rptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic full;
   logic empty;
   logic rd_acc;
   logic wr_acc;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
   assign empty  = (wptr_q == rptr_q);
   assign rd_acc = bus.rd_pulse & ~empty;
   assign wr_acc = bus.wr_pulse & (~full | rd_acc);

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      dout_d       = dout_q;
      dout_valid_d = rd_acc;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;

      if (wr_acc) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
         rptr_d = rptr_q + 1'b1;
         dout_d = mem_q[rptr_q[ADDR_W-1:0]];
      end

      // Set events outrank a simultaneous clear.
      if (bus.wr_pulse && !wr_acc) begin
         overflow_d = 1'b1;
      end else if (bus.clr_err) begin
         overflow_d = 1'b0;
      end

      if (bus.rd_pulse && empty) begin
         underflow_d = 1'b1;
      end else if (bus.clr_err) begin
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage is left unreset; a push into a full FIFO with a pop reuses the slot being read.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wptr_q[ADDR_W-1:0]] <= bus.din;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.count      = wptr_q - rptr_q;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_pulse_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pulse_fifo : directed scoreboard bench for pulse_fifo           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_pulse_fifo;
   logic clk;
   logic rst;

   pulse_fifo_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   pulse_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
      bus.wr_pulse = wr;
      bus.rd_pulse = rd;
      bus.din      = d;
      bus.clr_err  = clr;
      @(posedge clk);
      #1;
      bus.wr_pulse = 1'b0;
      bus.rd_pulse = 1'b0;
      bus.din      = 8'h00;
      bus.clr_err  = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      step(1'b1, 1'b0, d, 1'b0);
   endtask

   task automatic pop(input logic [7:0] e);
      exp_q.push_back(e);
      step(1'b0, 1'b1, 8'h00, 1'b0);
   endtask

   // Monitor: every presented word must match the oldest expected one.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.dout_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pop: got dout=0x%0h, expected no dout_valid", bus.dout);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.dout !== e) begin
               errors++;
               $display("FAIL pop_data: got 0x%0h, expected 0x%0h", bus.dout, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.wr_pulse = 1'b0;
      bus.rd_pulse = 1'b0;
      bus.din      = 8'h00;
      bus.clr_err  = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_dout", 32'(bus.dout), 0);
      chk("rst_dvalid", 32'(bus.dout_valid), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_unf", 32'(bus.underflow), 0);
      @(negedge clk);
      rst = 1'b1;

      // Pop from empty
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("unf_set", 32'(bus.underflow), 1);
      chk("unf_dout", 32'(bus.dout), 0);
      chk("unf_dvalid", 32'(bus.dout_valid), 0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("unf_clr", 32'(bus.underflow), 0);

      // Basic ordering
      push(8'h11); push(8'h22); push(8'h33);
      chk("basic_count", 32'(bus.count), 3);
      chk("basic_empty", 32'(bus.empty), 0);
      pop(8'h11); pop(8'h22); pop(8'h33);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("basic_dvalid_drop", 32'(bus.dout_valid), 0);
      chk("basic_empty_after", 32'(bus.empty), 1);
      chk("basic_count_after", 32'(bus.count), 0);

      // Fill, overflow, drain
      for (int i = 1; i <= 8; i++) push(8'(i));
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_count", 32'(bus.count), 8);
      push(8'hFF);
      chk("ovf_set", 32'(bus.overflow), 1);
      chk("ovf_count", 32'(bus.count), 8);
      for (int i = 1; i <= 8; i++) pop(8'(i));
      chk("drain_empty", 32'(bus.empty), 1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("ovf_clr", 32'(bus.overflow), 0);

      // Simultaneous push/pop at full
      for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
      exp_q.push_back(8'h41);
      step(1'b1, 1'b1, 8'hAA, 1'b0);
      chk("fullrw_count", 32'(bus.count), 8);
      chk("fullrw_ovf", 32'(bus.overflow), 0);
      chk("fullrw_full", 32'(bus.full), 1);
      for (int i = 1; i < 8; i++) pop(8'h41 + 8'(i));
      pop(8'hAA);
      chk("fullrw_empty", 32'(bus.empty), 1);

      // Simultaneous push/pop at empty
      step(1'b1, 1'b1, 8'h5C, 1'b0);
      chk("emptyrw_count", 32'(bus.count), 1);
      chk("emptyrw_unf", 32'(bus.underflow), 1);
      chk("emptyrw_dvalid", 32'(bus.dout_valid), 0);
      pop(8'h5C);

      // Alternating traffic across pointer wrap
      for (int i = 0; i < 10; i++) begin
         push(8'(i));
         chk("alt_count1", 32'(bus.count), 1);
         pop(8'(i));
         chk("alt_count0", 32'(bus.count), 0);
      end

      // Asynchronous reset mid-stream
      push(8'h77); push(8'h78);
      pop(8'h77);
      push(8'h79);
      chk("mid_count", 32'(bus.count), 2);
      chk("mid_unf_sticky", 32'(bus.underflow), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count), 0);
      chk("arst_dout", 32'(bus.dout), 0);
      chk("arst_empty", 32'(bus.empty), 1);
      chk("arst_unf", 32'(bus.underflow), 0);
      chk("arst_ovf", 32'(bus.overflow), 0);
      @(negedge clk);
      rst = 1'b1;
      push(8'h99);
      chk("post_count", 32'(bus.count), 1);
      pop(8'h99);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("post_empty", 32'(bus.empty), 1);
      chk("post_dvalid", 32'(bus.dout_valid), 0);

      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
